// File: rtl/vic_bus_pkg.sv
// Shared types and memory map for the VIC-20 expansion-port bus master and its address decoder.
package vic_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_e;

  localparam int SEL_W    = 9;
  localparam int SEL_RAM1 = 0;
  localparam int SEL_RAM2 = 1;
  localparam int SEL_RAM3 = 2;
  localparam int SEL_BLK1 = 3;
  localparam int SEL_BLK2 = 4;
  localparam int SEL_BLK3 = 5;
  localparam int SEL_BLK5 = 6;
  localparam int SEL_IO2  = 7;
  localparam int SEL_IO3  = 8;

  typedef struct packed {
    logic [15:0] base;
    logic [15:0] limit;
  } map_range_t;

  // Indexed by the SEL_* constants; ranges are disjoint so at most one select fires.
  localparam map_range_t MEM_MAP [SEL_W] = '{
    '{16'h0400, 16'h07FF},
    '{16'h0800, 16'h0BFF},
    '{16'h0C00, 16'h0FFF},
    '{16'h2000, 16'h3FFF},
    '{16'h4000, 16'h5FFF},
    '{16'h6000, 16'h7FFF},
    '{16'hA000, 16'hBFFF},
    '{16'h9800, 16'h9BFF},
    '{16'h9C00, 16'h9FFF}
  };

  function automatic logic in_range(input logic [15:0] a, input map_range_t r);
    return (a >= r.base) && (a <= r.limit);
  endfunction

endpackage

// File: rtl/vic_addr_decode.sv
// Combinational VIC-20 memory-map decoder: CPU address to active-low select vector plus unmapped flag.
module vic_addr_decode
  import vic_bus_pkg::*;
(
  input  logic [15:0]      addr,
  output logic [SEL_W-1:0] sel_n,
  output logic             unmapped
);

  always_comb begin
    sel_n = '1;
    for (int i = 0; i < SEL_W; i++) begin
      if (in_range(addr, MEM_MAP[i])) sel_n[i] = 1'b0;
    end
    unmapped = &sel_n;
  end

endmodule

// File: rtl/vic_bus_master.sv
// Host-side VIC-20 expansion-port initiator: turns one req/ack transaction into a single
// phi2 bus cycle (SETUP with phi2 low, ACTIVE with phi2 high, one HOLD clock for write hold).
module vic_bus_master
  import vic_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        busy,
  output logic        unmapped,
  output logic        phi2,
  output logic        r_w,
  output logic [12:0] address,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        ram1,
  output logic        ram2,
  output logic        ram3,
  output logic        blk1,
  output logic        blk2,
  output logic        blk3,
  output logic        blk5,
  output logic [3:2]  io
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PHASE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             phi2_q, phi2_d;
  logic             r_w_q, r_w_d;
  logic [12:0]      address_q, address_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_oe_q, data_oe_d;
  logic [SEL_W-1:0] sel_n_q, sel_n_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             unmapped_q, unmapped_d;

  logic [SEL_W-1:0] dec_sel_n;
  logic             dec_unmapped;

  vic_addr_decode u_decode (
    .addr     (addr_q),
    .sel_n    (dec_sel_n),
    .unmapped (dec_unmapped)
  );

  // Bus pins are derived from the next state so every output leaves a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    r_w_d      = r_w_q;
    address_d  = address_q;
    rdata_d    = rdata_q;
    unmapped_d = unmapped_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d   = SETUP;
          cnt_d     = CNT_RELOAD;
          we_d      = we;
          addr_d    = addr;
          wdata_d   = wdata;
          address_d = addr[12:0];
          r_w_d     = ~we;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACTIVE;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q == '0) begin
          state_d    = HOLD;
          unmapped_d = dec_unmapped;
          if (!we_q) rdata_d = data_in;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    phi2_d     = (state_d == ACTIVE);
    sel_n_d    = (state_d == ACTIVE) ? dec_sel_n : '1;
    data_oe_d  = we_q && ((state_d == ACTIVE) || (state_d == HOLD));
    data_out_d = data_oe_d ? wdata_q : data_out_q;
    ack_d      = (state_d == HOLD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      phi2_q     <= 1'b0;
      r_w_q      <= 1'b1;
      address_q  <= '0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      sel_n_q    <= '1;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
      unmapped_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      phi2_q     <= phi2_d;
      r_w_q      <= r_w_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      sel_n_q    <= sel_n_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign unmapped = unmapped_q;
  assign phi2     = phi2_q;
  assign r_w      = r_w_q;
  assign address  = address_q;
  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign ram1     = sel_n_q[SEL_RAM1];
  assign ram2     = sel_n_q[SEL_RAM2];
  assign ram3     = sel_n_q[SEL_RAM3];
  assign blk1     = sel_n_q[SEL_BLK1];
  assign blk2     = sel_n_q[SEL_BLK2];
  assign blk3     = sel_n_q[SEL_BLK3];
  assign blk5     = sel_n_q[SEL_BLK5];
  assign io[2]    = sel_n_q[SEL_IO2];
  assign io[3]    = sel_n_q[SEL_IO3];

endmodule

// File: tb/tb_vic_bus_master.sv
// Scoreboard bench for vic_bus_master: a slow-phase instance (PHASE_CYCLES=4) under directed
// and random traffic, and a PHASE_CYCLES=1 instance for back-to-back held-req cycles.
module tb_vic_bus_master;

  localparam int PC_A = 4;
  localparam int PC_B = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0, data_in = '0;
  logic [7:0]  rdata, data_out;
  logic        ack, busy, unmapped, phi2, r_w, data_oe;
  logic [12:0] address;
  logic        ram1, ram2, ram3, blk1, blk2, blk3, blk5;
  logic [3:2]  io;

  logic        req_b = 1'b0;
  logic [15:0] addr_b = '0;
  logic [7:0]  rdata_b, data_out_b, data_in_b;
  logic        ack_b, busy_b, unmapped_b, phi2_b, r_w_b, data_oe_b;
  logic [12:0] address_b;
  logic        ram1_b, ram2_b, ram3_b, blk1_b, blk2_b, blk3_b, blk5_b;
  logic [3:2]  io_b;

  vic_bus_master #(.PHASE_CYCLES(PC_A), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .unmapped(unmapped), .phi2(phi2), .r_w(r_w),
    .address(address), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .ram1(ram1), .ram2(ram2), .ram3(ram3), .blk1(blk1), .blk2(blk2), .blk3(blk3),
    .blk5(blk5), .io(io)
  );

  vic_bus_master #(.PHASE_CYCLES(PC_B), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .we(1'b0), .addr(addr_b), .wdata(8'h00),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b), .unmapped(unmapped_b), .phi2(phi2_b),
    .r_w(r_w_b), .address(address_b), .data_out(data_out_b), .data_oe(data_oe_b),
    .data_in(data_in_b), .ram1(ram1_b), .ram2(ram2_b), .ram3(ram3_b), .blk1(blk1_b),
    .blk2(blk2_b), .blk3(blk3_b), .blk5(blk5_b), .io(io_b)
  );

  // The PC=1 cartridge answers with a value that identifies which block it saw selected.
  assign data_in_b = !blk1_b ? 8'h11 : !blk2_b ? 8'h22 : !blk3_b ? 8'h33 : 8'hEE;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic [8:0]  sel;
    logic        unmapped;
    int          ack_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_b_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic [7:0] model_rdata = 8'h00;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Memory map straight from the VIC-20 table; bit order ram1,ram2,ram3,blk1,blk2,blk3,blk5,io2,io3.
  function automatic logic [8:0] model_sel(input logic [15:0] a);
    logic [8:0] v;
    v = 9'h1FF;
    if (a >= 16'h0400 && a < 16'h0800) v[0] = 1'b0;
    if (a >= 16'h0800 && a < 16'h0C00) v[1] = 1'b0;
    if (a >= 16'h0C00 && a < 16'h1000) v[2] = 1'b0;
    if (a >= 16'h2000 && a < 16'h4000) v[3] = 1'b0;
    if (a >= 16'h4000 && a < 16'h6000) v[4] = 1'b0;
    if (a >= 16'h6000 && a < 16'h8000) v[5] = 1'b0;
    if (a >= 16'hA000 && a < 16'hC000) v[6] = 1'b0;
    if (a >= 16'h9800 && a < 16'h9C00) v[7] = 1'b0;
    if (a >= 16'h9C00 && a < 16'hA000) v[8] = 1'b0;
    return v;
  endfunction

  // Monitor for the PC=4 instance: accumulates per-cycle bus behaviour and settles it on ack.
  int   n_phi2 = 0, n_sel = 0, n_busy = 0, n_oe = 0, bad_sel = 0, bad_data = 0, bad_bus = 0;
  exp_t mon_e;
  logic [8:0] obs;

  always @(negedge clock) begin
    if (reset) begin
      n_phi2 = 0; n_sel = 0; n_busy = 0; n_oe = 0; bad_sel = 0; bad_data = 0; bad_bus = 0;
    end else begin
      obs = {io[3], io[2], blk5, blk3, blk2, blk1, ram3, ram2, ram1};
      if (phi2) n_phi2++;
      if (busy) n_busy++;
      if (obs != 9'h1FF) n_sel++;
      if (data_oe) n_oe++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q[0];
        if (obs !== (phi2 ? mon_e.sel : 9'h1FF)) bad_sel++;
        if (data_oe && data_out !== mon_e.wdata) bad_data++;
        if (busy && (address !== mon_e.addr[12:0] || r_w !== !mon_e.we)) bad_bus++;
      end else if (obs != 9'h1FF) begin
        bad_sel++;
      end
      if (ack) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rdata", rdata, mon_e.rdata);
          checkOutput("unmapped", unmapped, mon_e.unmapped);
          checkOutput("ack_latency", cyc, mon_e.ack_cyc);
          checkOutput("phi2_high_clocks", n_phi2, PC_A);
          checkOutput("select_low_clocks", n_sel, mon_e.unmapped ? 0 : PC_A);
          checkOutput("busy_clocks", n_busy, 2 * PC_A + 1);
          checkOutput("data_oe_clocks", n_oe, mon_e.we ? PC_A + 1 : 0);
          checkOutput("select_pattern_errs", bad_sel, 0);
          checkOutput("data_out_errs", bad_data, 0);
          checkOutput("addr_rw_errs", bad_bus, 0);
        end
        n_phi2 = 0; n_sel = 0; n_busy = 0; n_oe = 0; bad_sel = 0; bad_data = 0; bad_bus = 0;
      end
    end
  end

  // Monitor for the PC=1 instance.
  exp_t mon_b;
  always @(negedge clock) begin
    if (!reset && ack_b) begin
      if (exp_b_q.size() == 0) begin
        checkOutput("b_unexpected_ack", 32'd1, 32'd0);
      end else begin
        mon_b = exp_b_q.pop_front();
        checkOutput("b_rdata", rdata_b, mon_b.rdata);
        checkOutput("b_unmapped", unmapped_b, 32'd0);
        checkOutput("b_ack_cycle", cyc, mon_b.ack_cyc);
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_phi2"}, phi2, 0);
    checkOutput({tag, "_r_w"}, r_w, 1);
    checkOutput({tag, "_address"}, address, 0);
    checkOutput({tag, "_data_out"}, data_out, 0);
    checkOutput({tag, "_data_oe"}, data_oe, 0);
    checkOutput({tag, "_selects"}, {io[3], io[2], blk5, blk3, blk2, blk1, ram3, ram2, ram1}, 9'h1FF);
    checkOutput({tag, "_ack"}, ack, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_rdata"}, rdata, 0);
    checkOutput({tag, "_unmapped"}, unmapped, 0);
  endtask

  task automatic pushExpected(input logic w, input logic [15:0] a, input logic [7:0] wd,
                              input logic [7:0] din);
    exp_t e;
    e.we       = w;
    e.addr     = a;
    e.wdata    = wd;
    if (!w) model_rdata = din;
    e.rdata    = model_rdata;
    e.sel      = model_sel(a);
    e.unmapped = (e.sel == 9'h1FF);
    e.ack_cyc  = cyc + 1 + 2 * PC_A;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [7:0] wd,
                               input logic [7:0] din);
    int k;
    @(negedge clock);
    req = 1'b1; we = w; addr = a; wdata = wd; data_in = din;
    pushExpected(w, a, wd, din);
    @(negedge clock);
    req = 1'b0;
    k = 0;
    while (ack !== 1'b1 && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (ack !== 1'b1) begin
      checkOutput("ack_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  logic [15:0] edges [18] = '{16'h03FF, 16'h0400, 16'h07FF, 16'h0800, 16'h0FFF, 16'h1000,
                              16'h1FFF, 16'h2000, 16'h7FFF, 16'h8000, 16'h97FF, 16'h9800,
                              16'h9BFF, 16'h9C00, 16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};

  initial begin
    int seen, k;
    logic [15:0] ra;
    $display("[TB] start");
    repeat (3) @(negedge clock);
    checkResetValues("por");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    applyStimulus(1'b0, 16'hA123, 8'h00, 8'h5A);
    applyStimulus(1'b1, 16'h0456, 8'hC3, 8'h99);
    applyStimulus(1'b0, 16'h9C10, 8'h00, 8'h71);
    applyStimulus(1'b0, 16'hC000, 8'h00, 8'h3E);

    // Abandon a write on its second ACTIVE clock.
    @(negedge clock);
    req = 1'b1; we = 1'b1; addr = 16'h0456; wdata = 8'h3C;
    pushExpected(1'b1, 16'h0456, 8'h3C, 8'h00);
    @(negedge clock);
    req = 1'b0;
    seen = 0;
    k = 0;
    while (seen < 2 && k < 50) begin
      if (phi2) seen++;
      if (seen < 2) begin
        @(negedge clock);
        k++;
      end
    end
    checkOutput("reached_2nd_active", seen, 2);
    reset = 1'b1;
    #1;
    checkResetValues("midcycle");
    exp_q.delete();
    model_rdata = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    applyStimulus(1'b0, 16'h2345, 8'h00, 8'hA7);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       ra = 16'($urandom);
        1:       ra = edges[$urandom_range(0, 17)];
        default: ra = 16'($urandom_range(0, 16'hBFFF));
      endcase
      applyStimulus(1'($urandom), ra, 8'($urandom), 8'($urandom));
    end

    // Held req on the PC=1 instance: three reads, acks four clocks apart.
    @(negedge clock);
    req_b = 1'b1;
    addr_b = 16'h2000;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.we = 1'b0; e.addr = 16'h2000 + 16'(j) * 16'h2000; e.wdata = 8'h00;
      e.rdata = 8'h11 * 8'(j + 1); e.sel = 9'h1FF; e.unmapped = 1'b0;
      e.ack_cyc = cyc + 1 + 2 * PC_B + 4 * j;
      exp_b_q.push_back(e);
    end
    for (int j = 0; j < 3; j++) begin
      k = 0;
      while (ack_b !== 1'b1 && k < 20) begin
        @(negedge clock);
        k++;
      end
      if (ack_b !== 1'b1) checkOutput("b_ack_timeout", 32'd0, 32'd1);
      if (j == 0) addr_b = 16'h4000;
      else if (j == 1) addr_b = 16'h6000;
      else req_b = 1'b0;
      @(negedge clock);
    end

    repeat (4) @(negedge clock);
    checkOutput("queue_a_drained", exp_q.size(), 0);
    checkOutput("queue_b_drained", exp_b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
